// File: rtl/mod_cfg_pkg.sv
// mod_cfg_pkg: shared types, widths and helpers for the modulated-clock
// reconfiguration sequencer.
`default_nettype none

package mod_cfg_pkg;

  localparam int FREQ_W  = 3;
  localparam int PHASE_W = 5;
  localparam int DUTY_W  = 4;
  localparam int CNT_W   = 16;

  localparam int ERR_BAD_FREQ     = 0;
  localparam int ERR_LOCK_TIMEOUT = 1;

  // Highest-frequency PLL variant only supports codes below this limit.
  localparam int HF_CODE_LIMIT = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DRAIN     = 3'd1,
    ST_APPLY     = 3'd2,
    ST_LOCK_WAIT = 3'd3,
    ST_SETTLE    = 3'd4,
    ST_RUN       = 3'd5,
    ST_ERR       = 3'd6
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Low-order select bits the high-frequency variant cannot resolve.
  function automatic logic [1:0] hf_mask(input logic hf, input logic [FREQ_W-1:0] code);
    if (!hf)                      return 2'b00;
    if (code <= FREQ_W'(1))       return 2'b01;
    if (code == FREQ_W'(2))       return 2'b11;
    return 2'b00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mod_cfg_sequencer_if.sv
// mod_cfg_sequencer_if: host request handshake plus generator select/drain
// bus for the reconfiguration sequencer.
`default_nettype none

interface mod_cfg_sequencer_if;
  import mod_cfg_pkg::*;

  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [FREQ_W-1:0]    freq_sel_req;
  logic [PHASE_W-1:0]   phase_sel_req;
  logic [DUTY_W-1:0]    duty_sel_req;
  logic                 pll_locked;
  logic                 flag_high_freq;
  logic [FREQ_W-1:0]    freq_sel;
  logic [PHASE_W-1:0]   phase_sel;
  logic [DUTY_W-1:0]    duty_sel;
  logic                 drain_b;
  logic                 mod_active;
  logic [1:0]           cfg_err;

  modport master (
    output cfg_valid, freq_sel_req, phase_sel_req, duty_sel_req,
           pll_locked, flag_high_freq,
    input  cfg_ready, freq_sel, phase_sel, duty_sel, drain_b,
           mod_active, cfg_err
  );

  modport slave (
    input  cfg_valid, freq_sel_req, phase_sel_req, duty_sel_req,
           pll_locked, flag_high_freq,
    output cfg_ready, freq_sel, phase_sel, duty_sel, drain_b,
           mod_active, cfg_err
  );

endinterface

`default_nettype wire

// File: rtl/mod_lock_filter.sv
// mod_lock_filter: 2-flop synchroniser for PLL lock plus a consecutive-high
// counter that qualifies lock as stable.
`default_nettype none

module mod_lock_filter
  import mod_cfg_pkg::*;
#(
  parameter int LOCK_STABLE = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_locked,
  input  logic restart,
  output logic lock_stable,
  output logic lock_lost
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= pll_locked;
      sync2 <= sync1;
      if (restart || !sync2)
        cnt <= '0;
      else
        cnt <= sat_inc(cnt);
    end
  end

  // Asserted on the cycle that completes LOCK_STABLE consecutive high samples.
  assign lock_stable = sync2 && (cnt >= STABLE_LAST);
  assign lock_lost   = !sync2;

endmodule

`default_nettype wire

// File: rtl/mod_cfg_sequencer.sv
// mod_cfg_sequencer: drain/apply/lock/settle sequencing of generator selects.
// Optional MOD_CFG_FAST_PHASE_EN skips lock wait when the frequency code is unchanged.
`default_nettype none

module mod_cfg_sequencer
  import mod_cfg_pkg::*;
#(
  parameter int DRAIN_CYCLES  = 16,
  parameter int LOCK_STABLE   = 32,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int SETTLE_CYCLES = 8,
  parameter int NUM_FREQ      = 6
) (
  input  logic               user_clock,
  input  logic               reset_b,
  mod_cfg_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    tcnt;
  logic [FREQ_W-1:0]   pend_freq;
  logic [PHASE_W-1:0]  pend_phase;
  logic [DUTY_W-1:0]   pend_duty;
  logic                relock;
  logic                pend_fast;
  logic [FREQ_W-1:0]   freq_sel;
  logic [PHASE_W-1:0]  phase_sel;
  logic [DUTY_W-1:0]   duty_sel;
  logic                drain_b;
  logic                mod_active;
  logic                cfg_ready;
  logic [1:0]          cfg_err;

  logic                lock_stable;
  logic                lock_lost;
  logic                accept;
  logic                bad_req;
  logic                fast_ok;
  logic [1:0]          mask;

  mod_lock_filter #(
    .LOCK_STABLE (LOCK_STABLE)
  ) u_lock_filter (
    .clk         (user_clock),
    .rst_n       (reset_b),
    .pll_locked  (bus.pll_locked),
    .restart     (state != ST_LOCK_WAIT),
    .lock_stable (lock_stable),
    .lock_lost   (lock_lost)
  );

  assign accept  = bus.cfg_valid && cfg_ready;
  assign bad_req = (int'(bus.freq_sel_req) >= NUM_FREQ) ||
                   (bus.flag_high_freq && (int'(bus.freq_sel_req) >= HF_CODE_LIMIT));
  assign mask    = hf_mask(bus.flag_high_freq, pend_freq);

`ifdef MOD_CFG_FAST_PHASE_EN
  // Same frequency code leaves the PLL untouched, so relock is unnecessary.
  assign fast_ok = (bus.freq_sel_req == freq_sel);
`else
  assign fast_ok = 1'b0;
`endif

  always_ff @(posedge user_clock or negedge reset_b) begin
    if (!reset_b) begin
      state      <= ST_LOCK_WAIT;
      cnt        <= '0;
      tcnt       <= '0;
      pend_freq  <= '0;
      pend_phase <= '0;
      pend_duty  <= '0;
      relock     <= 1'b0;
      pend_fast  <= 1'b0;
      freq_sel   <= '0;
      phase_sel  <= '0;
      duty_sel   <= '0;
      drain_b    <= 1'b0;
      mod_active <= 1'b0;
      cfg_ready  <= 1'b0;
      cfg_err    <= '0;
    end else begin
      case (state)
        ST_DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            cnt   <= '0;
            tcnt  <= '0;
            state <= relock ? ST_LOCK_WAIT : ST_APPLY;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        ST_APPLY: begin
          freq_sel  <= pend_freq;
          phase_sel <= pend_phase & ~{{(PHASE_W-2){1'b0}}, mask};
          duty_sel  <= pend_duty  & ~{{(DUTY_W-2){1'b0}}, mask};
          cnt       <= '0;
          tcnt      <= '0;
          state     <= pend_fast ? ST_SETTLE : ST_LOCK_WAIT;
        end

        ST_LOCK_WAIT: begin
          if (lock_stable) begin
            cnt   <= '0;
            state <= ST_SETTLE;
          end else if (tcnt == TIMEOUT_LAST) begin
            cfg_err[ERR_LOCK_TIMEOUT] <= 1'b1;
            cfg_ready                 <= 1'b1;
            state                     <= ST_ERR;
          end else begin
            tcnt <= sat_inc(tcnt);
          end
        end

        ST_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            drain_b    <= 1'b1;
            mod_active <= 1'b1;
            cfg_ready  <= 1'b1;
            state      <= ST_RUN;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        ST_RUN, ST_ERR: begin
          if (accept && bad_req) begin
            cfg_err[ERR_BAD_FREQ] <= 1'b1;
          end else if (accept) begin
            pend_freq  <= bus.freq_sel_req;
            pend_phase <= bus.phase_sel_req;
            pend_duty  <= bus.duty_sel_req;
            pend_fast  <= fast_ok;
            relock     <= 1'b0;
            cfg_err    <= '0;
            cnt        <= '0;
            drain_b    <= 1'b0;
            mod_active <= 1'b0;
            cfg_ready  <= 1'b0;
            state      <= ST_DRAIN;
          end else if (state == ST_RUN && lock_lost) begin
            // Lost lock keeps the applied codes; drain then relock only.
            relock     <= 1'b1;
            cnt        <= '0;
            drain_b    <= 1'b0;
            mod_active <= 1'b0;
            cfg_ready  <= 1'b0;
            state      <= ST_DRAIN;
          end
        end

        default: begin
          tcnt  <= '0;
          state <= ST_LOCK_WAIT;
        end
      endcase
    end
  end

  assign bus.freq_sel   = freq_sel;
  assign bus.phase_sel  = phase_sel;
  assign bus.duty_sel   = duty_sel;
  assign bus.drain_b    = drain_b;
  assign bus.mod_active = mod_active;
  assign bus.cfg_ready  = cfg_ready;
  assign bus.cfg_err    = cfg_err;

endmodule

`default_nettype wire

// File: tb/tb_mod_cfg_sequencer.sv
// tb_mod_cfg_sequencer: directed scoreboard bench for mod_cfg_sequencer.
`default_nettype none

module tb_mod_cfg_sequencer;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mod_cfg_sequencer_if bus ();

  mod_cfg_sequencer #(
    .DRAIN_CYCLES  (16),
    .LOCK_STABLE   (32),
    .LOCK_TIMEOUT  (100),
    .SETTLE_CYCLES (8),
    .NUM_FREQ      (6)
  ) dut (
    .user_clock (clk),
    .reset_b    (rst_n),
    .bus        (bus)
  );

  typedef struct {
    string       tag;
    int          cyc;
    logic [2:0]  f;
    logic [4:0]  p;
    logic [3:0]  d;
    logic [1:0]  err;
    logic        ma;
    logic        db;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

`ifdef MOD_CFG_FAST_PHASE_EN
  localparam int FAST_CYC = 25;
`else
  localparam int FAST_CYC = 57;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic push(input string tag, input int cyc, input logic [2:0] f, input logic [4:0] p,
                      input logic [3:0] d, input logic [1:0] err, input logic ma, input logic db);
    exp_t e;
    e.tag = tag; e.cyc = cyc; e.f = f; e.p = p; e.d = d; e.err = err; e.ma = ma; e.db = db;
    sb.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic request(input logic [2:0] f, input logic [4:0] p, input logic [3:0] d);
    bus.cfg_valid     = 1'b1;
    bus.freq_sel_req  = f;
    bus.phase_sel_req = p;
    bus.duty_sel_req  = d;
    @(posedge clk);
    @(negedge clk);
    bus.cfg_valid = 1'b0;
  endtask

  // Waits for CFG_READY (RUN or ERR) and compares against the oldest expectation.
  task automatic wait_ready(input int n0);
    int   n;
    exp_t e;
    n = n0;
    while (bus.cfg_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    chk({e.tag, ".cycles"},     n,              e.cyc);
    chk({e.tag, ".freq_sel"},   bus.freq_sel,   e.f);
    chk({e.tag, ".phase_sel"},  bus.phase_sel,  e.p);
    chk({e.tag, ".duty_sel"},   bus.duty_sel,   e.d);
    chk({e.tag, ".cfg_err"},    bus.cfg_err,    e.err);
    chk({e.tag, ".mod_active"}, bus.mod_active, e.ma);
    chk({e.tag, ".drain_b"},    bus.drain_b,    e.db);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n              = 1'b0;
    bus.cfg_valid      = 1'b0;
    bus.freq_sel_req   = '0;
    bus.phase_sel_req  = '0;
    bus.duty_sel_req   = '0;
    bus.pll_locked     = 1'b1;
    bus.flag_high_freq = 1'b0;

    // Reset values, then power-up lock check with code 0.
    step(3);
    chk("rst.drain_b",    bus.drain_b,    0);
    chk("rst.cfg_ready",  bus.cfg_ready,  0);
    chk("rst.mod_active", bus.mod_active, 0);
    chk("rst.freq_sel",   bus.freq_sel,   0);
    chk("rst.cfg_err",    bus.cfg_err,    0);
    push("powerup", 42, 3'd0, 5'd0, 4'd0, 2'b00, 1'b1, 1'b1);
    rst_n = 1'b1;
    wait_ready(0);

    // Full reconfiguration; CFG_VALID during DRAIN must be ignored.
    push("req_4_17_9", 57, 3'd4, 5'd17, 4'd9, 2'b00, 1'b1, 1'b1);
    request(3'd4, 5'd17, 4'd9);
    chk("acc.drain_b",    bus.drain_b,    0);
    chk("acc.mod_active", bus.mod_active, 0);
    chk("acc.cfg_ready",  bus.cfg_ready,  0);
    step(5);
    bus.cfg_valid    = 1'b1;
    bus.freq_sel_req = 3'd7;
    step(1);
    bus.cfg_valid = 1'b0;
    chk("ignored.cfg_err", bus.cfg_err, 0);
    step(10);
    chk("drain16.freq_sel", bus.freq_sel, 0);
    step(1);
    chk("apply.freq_sel",  bus.freq_sel,  4);
    chk("apply.phase_sel", bus.phase_sel, 17);
    chk("apply.duty_sel",  bus.duty_sel,  9);
    chk("apply.drain_b",   bus.drain_b,   0);
    wait_ready(17);

    // High-frequency variant masks two low bits for code 2.
    bus.flag_high_freq = 1'b1;
    push("hf_code2", 57, 3'd2, 5'd28, 4'd12, 2'b00, 1'b1, 1'b1);
    request(3'd2, 5'd31, 4'd15);
    wait_ready(0);

    // Code 3 invalid for high-frequency variant: reject, state unchanged.
    request(3'd3, 5'd1, 4'd1);
    chk("rej3.cfg_err",    bus.cfg_err,    2'b01);
    chk("rej3.mod_active", bus.mod_active, 1);
    chk("rej3.cfg_ready",  bus.cfg_ready,  1);
    chk("rej3.phase_sel",  bus.phase_sel,  28);
    chk("rej3.freq_sel",   bus.freq_sel,   2);

    // NUM_FREQ boundary: 6 rejected, 5 accepted and error cleared.
    bus.flag_high_freq = 1'b0;
    request(3'd6, 5'd0, 4'd0);
    chk("rej6.cfg_err",  bus.cfg_err,  2'b01);
    chk("rej6.drain_b",  bus.drain_b,  1);
    push("code5", 57, 3'd5, 5'd3, 4'd1, 2'b00, 1'b1, 1'b1);
    request(3'd5, 5'd3, 4'd1);
    chk("acc5.cfg_err", bus.cfg_err, 0);
    wait_ready(0);

    // Lock never arrives: ERR after the timeout with codes applied.
    bus.pll_locked = 1'b0;
    push("timeout", 117, 3'd1, 5'd5, 4'd6, 2'b10, 1'b0, 1'b0);
    request(3'd1, 5'd5, 4'd6);
    wait_ready(0);

    // Retry from ERR with lock present.
    bus.pll_locked = 1'b1;
    push("recover", 57, 3'd0, 5'd0, 4'd0, 2'b00, 1'b1, 1'b1);
    request(3'd0, 5'd0, 4'd0);
    wait_ready(0);

    // Lock dropout in RUN: drain, relock with same codes, skipping APPLY.
    push("relock", 59, 3'd0, 5'd0, 4'd0, 2'b00, 1'b1, 1'b1);
    bus.pll_locked = 1'b0;
    step(3);
    chk("loss.mod_active", bus.mod_active, 0);
    chk("loss.drain_b",    bus.drain_b,    0);
    step(2);
    bus.pll_locked = 1'b1;
    wait_ready(5);

    // Same frequency code, phase/duty change.
    push("same_freq", FAST_CYC, 3'd0, 5'd9, 4'd4, 2'b00, 1'b1, 1'b1);
    request(3'd0, 5'd9, 4'd4);
    wait_ready(0);

    // High-frequency variant masks bit 0 for code 1.
    bus.flag_high_freq = 1'b1;
    push("hf_code1", 57, 3'd1, 5'd30, 4'd14, 2'b00, 1'b1, 1'b1);
    request(3'd1, 5'd31, 4'd15);
    wait_ready(0);

    // Reset mid-sequence returns outputs to reset values at once.
    bus.flag_high_freq = 1'b0;
    request(3'd4, 5'd2, 4'd2);
    step(20);
    rst_n = 1'b0;
    #1;
    chk("midrst.freq_sel",  bus.freq_sel,  0);
    chk("midrst.phase_sel", bus.phase_sel, 0);
    chk("midrst.drain_b",   bus.drain_b,   0);
    chk("midrst.cfg_ready", bus.cfg_ready, 0);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
